// File: rtl/spio_status_led_generator_multi.sv
// Multi-device PWM status LED driver with sticky error latching, global brightness
// scaling and per-device host override of the displayed animation.
module spio_status_led_generator_multi #(
    parameter int NUM_DEVICES           = 1,
    parameter int PWM_BITS              = 7,
    parameter int ANIMATION_PERIOD_BITS = 27,
    parameter int PULSE_CYCLES          = 7500000,
    parameter int BLINK_BIT             = 22,
    parameter int ACTIVITY_TIMEOUT      = 18750000,
    parameter int ACTIVITY_TIMEOUT_BITS = 25
) (
    input  logic                       CLK_IN,
    input  logic                       RESET_IN,
    input  logic [NUM_DEVICES-1:0]     ERROR_IN,
    input  logic [NUM_DEVICES-1:0]     ERROR_CLEAR_IN,
    input  logic [NUM_DEVICES-1:0]     CONNECTED_IN,
    input  logic [NUM_DEVICES-1:0]     ACTIVITY_IN,
    input  logic [PWM_BITS-1:0]        BRIGHTNESS_IN,
    input  logic [NUM_DEVICES-1:0]     OVERRIDE_EN_IN,
    input  logic [3*NUM_DEVICES-1:0]   OVERRIDE_MODE_IN,
    output logic [NUM_DEVICES-1:0]     ERROR_LATCHED_OUT,
    output logic [NUM_DEVICES-1:0]     LED_OUT,
    output logic                       ANIMATION_REPEAT_OUT
);
    localparam int A  = ANIMATION_PERIOD_BITS;
    localparam int DW = PWM_BITS + 1;
    localparam int PW = 2 * PWM_BITS + 1;
    localparam logic [DW-1:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [A-1:0] HALF_PERIOD = {1'b1, {(A-1){1'b0}}};
    localparam logic [A-1:0] PULSE_LEN = A'(PULSE_CYCLES);
    localparam logic [ACTIVITY_TIMEOUT_BITS-1:0] TIMEOUT = ACTIVITY_TIMEOUT_BITS'(ACTIVITY_TIMEOUT);

    // Brightness b maps to a gain of (b+1)/2^PWM_BITS, truncated toward zero.
    function automatic logic [DW-1:0] scale_duty(input logic [DW-1:0] duty,
                                                 input logic [PWM_BITS-1:0] brt);
        logic [PW-1:0] prod;
        prod = PW'(duty) * (PW'(brt) + PW'(1));
        return prod[PW-1 -: DW];
    endfunction

    logic [PWM_BITS-1:0]              pwm_cnt;
    logic [A-1:0]                     period;
    logic [A-1:0]                     pulse_ofs;
    logic [PWM_BITS-1:0]              throb_t;
    logic [DW-1:0]                    pulse_p0, inv_pulse_p0, blink_p0, throb_p0;
    logic [NUM_DEVICES-1:0]           conn_p0, ovr_en_p0;
    logic [3*NUM_DEVICES-1:0]         ovr_mode_p0;
    logic [ACTIVITY_TIMEOUT_BITS-1:0] act_cnt_p0 [NUM_DEVICES];
    logic [PWM_BITS-1:0]              brt_p0, brt_p1;
    logic [DW-1:0]                    sel_duty   [NUM_DEVICES];
    logic [DW-1:0]                    duty_p1    [NUM_DEVICES];
    logic [DW-1:0]                    scaled_p2  [NUM_DEVICES];

    assign pulse_ofs = period - HALF_PERIOD;
    assign throb_t   = period[A-2 -: PWM_BITS];

    // Stage p0: free-running counters, animation values and registered inputs
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            pwm_cnt              <= '0;
            period               <= '0;
            ANIMATION_REPEAT_OUT <= 1'b0;
            pulse_p0             <= '0;
            inv_pulse_p0         <= '0;
            blink_p0             <= '0;
            throb_p0             <= '0;
            conn_p0              <= '0;
            ovr_en_p0            <= '0;
            ovr_mode_p0          <= '0;
            brt_p0               <= '0;
            ERROR_LATCHED_OUT    <= '0;
            for (int i = 0; i < NUM_DEVICES; i++) act_cnt_p0[i] <= '0;
        end else begin
            pwm_cnt              <= pwm_cnt + PWM_BITS'(1);
            period               <= period + A'(1);
            ANIMATION_REPEAT_OUT <= (period == '0);
            pulse_p0             <= (pulse_ofs < PULSE_LEN) ? FULL : '0;
            inv_pulse_p0         <= (pulse_ofs < PULSE_LEN) ? '0 : FULL;
            blink_p0             <= period[BLINK_BIT] ? FULL : '0;
            throb_p0             <= {1'b0, (period[A-1] ? ~throb_t : throb_t)};
            conn_p0              <= CONNECTED_IN;
            ovr_en_p0            <= OVERRIDE_EN_IN;
            ovr_mode_p0          <= OVERRIDE_MODE_IN;
            brt_p0               <= BRIGHTNESS_IN;
            for (int i = 0; i < NUM_DEVICES; i++) begin
                // A new error beats a clear arriving in the same cycle.
                if (ERROR_IN[i])
                    ERROR_LATCHED_OUT[i] <= 1'b1;
                else if (ERROR_CLEAR_IN[i])
                    ERROR_LATCHED_OUT[i] <= 1'b0;
                if (ACTIVITY_IN[i])
                    act_cnt_p0[i] <= TIMEOUT;
                else if (act_cnt_p0[i] != '0)
                    act_cnt_p0[i] <= act_cnt_p0[i] - ACTIVITY_TIMEOUT_BITS'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DEVICES; i++) begin
            sel_duty[i] = '0;
            if (ovr_en_p0[i]) begin
                case (ovr_mode_p0[3*i +: 3])
                    3'd1:    sel_duty[i] = FULL;
                    3'd2:    sel_duty[i] = pulse_p0;
                    3'd3:    sel_duty[i] = inv_pulse_p0;
                    3'd4:    sel_duty[i] = blink_p0;
                    3'd5:    sel_duty[i] = throb_p0;
                    default: sel_duty[i] = '0;
                endcase
            end else if (ERROR_LATCHED_OUT[i]) begin
                sel_duty[i] = inv_pulse_p0;
            end else if (conn_p0[i] && (act_cnt_p0[i] != '0)) begin
                sel_duty[i] = blink_p0;
            end else if (conn_p0[i]) begin
                sel_duty[i] = throb_p0;
            end else begin
                sel_duty[i] = pulse_p0;
            end
        end
    end

    // Stage p1: selected duty; p2: brightness-scaled duty; then PWM compare
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            brt_p1  <= '0;
            LED_OUT <= '0;
            for (int i = 0; i < NUM_DEVICES; i++) begin
                duty_p1[i]   <= '0;
                scaled_p2[i] <= '0;
            end
        end else begin
            brt_p1 <= brt_p0;
            for (int i = 0; i < NUM_DEVICES; i++) begin
                duty_p1[i]   <= sel_duty[i];
                scaled_p2[i] <= scale_duty(duty_p1[i], brt_p1);
                LED_OUT[i]   <= ({1'b0, pwm_cnt} < scaled_p2[i]);
            end
        end
    end
endmodule

// File: tb/tb_spio_status_led_generator_multi.sv
// Scoreboard bench: stimulus pushes expected outputs from a cycle-level behavioural
// model; an independent monitor pops and compares one entry per clock.
module tb_spio_status_led_generator_multi;
    localparam int ND = 2, PB = 3, APB = 8, PC = 16, BB = 4, AT = 20, ATB = 5;
    localparam int FULL = 1 << PB;
    localparam int PERIOD = 1 << APB;

    logic            CLK_IN = 1'b0;
    logic            RESET_IN = 1'b0;
    logic [ND-1:0]   ERROR_IN = '0, ERROR_CLEAR_IN = '0, CONNECTED_IN = '0, ACTIVITY_IN = '0;
    logic [PB-1:0]   BRIGHTNESS_IN = 3'd7;
    logic [ND-1:0]   OVERRIDE_EN_IN = '0;
    logic [3*ND-1:0] OVERRIDE_MODE_IN = '0;
    logic [ND-1:0]   ERROR_LATCHED_OUT, LED_OUT;
    logic            ANIMATION_REPEAT_OUT;

    spio_status_led_generator_multi #(
        .NUM_DEVICES(ND), .PWM_BITS(PB), .ANIMATION_PERIOD_BITS(APB), .PULSE_CYCLES(PC),
        .BLINK_BIT(BB), .ACTIVITY_TIMEOUT(AT), .ACTIVITY_TIMEOUT_BITS(ATB)
    ) dut (
        .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .ERROR_IN(ERROR_IN),
        .ERROR_CLEAR_IN(ERROR_CLEAR_IN), .CONNECTED_IN(CONNECTED_IN),
        .ACTIVITY_IN(ACTIVITY_IN), .BRIGHTNESS_IN(BRIGHTNESS_IN),
        .OVERRIDE_EN_IN(OVERRIDE_EN_IN), .OVERRIDE_MODE_IN(OVERRIDE_MODE_IN),
        .ERROR_LATCHED_OUT(ERROR_LATCHED_OUT), .LED_OUT(LED_OUT),
        .ANIMATION_REPEAT_OUT(ANIMATION_REPEAT_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        int            edge_no;
        logic [ND-1:0] led;
        logic [ND-1:0] err;
        logic          rep;
    } exp_t;

    exp_t exp_q[$];
    int   sc_q[$];
    int   n_edge;
    bit   m_latch [ND];
    int   last_act [ND];
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t mon_e;

    logic [ND-1:0]   conn_s = '0, oen_s = '0;
    logic [3*ND-1:0] mode_s = '0;
    logic [PB-1:0]   brt_s = 3'd7;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Animation levels as functions of the period counter value p.
    function automatic int anim(input int p, input int sel);
        int pulse, t;
        pulse = ((((p - PERIOD / 2) % PERIOD) + PERIOD) % PERIOD < PC) ? FULL : 0;
        t = (p >> (APB - 1 - PB)) % FULL;
        case (sel)
            1: return FULL;
            2: return pulse;
            3: return FULL - pulse;
            4: return ((p >> BB) & 1) ? FULL : 0;
            5: return (p >= PERIOD / 2) ? (FULL - 1 - t) : t;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        n_edge = 0;
        sc_q = '{0, 0, 0};
        exp_q.delete();
        for (int i = 0; i < ND; i++) begin
            m_latch[i] = 1'b0;
            last_act[i] = -100000;
        end
    endtask

    // Model the coming rising edge using the inputs currently driven.
    task automatic push_model();
        exp_t e;
        int p, old, sel, packed_sc;
        bit active;
        n_edge++;
        p = (n_edge - 1) % PERIOD;
        old = sc_q.pop_front();
        packed_sc = 0;
        for (int i = 0; i < ND; i++) begin
            if (ERROR_IN[i]) m_latch[i] = 1'b1;
            else if (ERROR_CLEAR_IN[i]) m_latch[i] = 1'b0;
            if (ACTIVITY_IN[i]) last_act[i] = n_edge;
            active = (n_edge - last_act[i]) < AT;
            if (OVERRIDE_EN_IN[i]) begin
                sel = int'(OVERRIDE_MODE_IN[3*i +: 3]);
                if (sel == 0 || sel > 5) sel = 0;
            end else if (m_latch[i]) sel = 3;
            else if (CONNECTED_IN[i] && active) sel = 4;
            else if (CONNECTED_IN[i]) sel = 5;
            else sel = 2;
            packed_sc |= ((anim(p, sel) * (int'(BRIGHTNESS_IN) + 1)) / FULL) << (8 * i);
            e.led[i] = ((n_edge - 1) % FULL) < ((old >> (8 * i)) & 255);
            e.err[i] = m_latch[i];
        end
        e.rep = (p == 0);
        e.edge_no = n_edge;
        sc_q.push_back(packed_sc);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [ND-1:0] err, input logic [ND-1:0] clr,
                         input logic [ND-1:0] act);
        ERROR_IN = err;
        ERROR_CLEAR_IN = clr;
        ACTIVITY_IN = act;
        CONNECTED_IN = conn_s;
        OVERRIDE_EN_IN = oen_s;
        OVERRIDE_MODE_IN = mode_s;
        BRIGHTNESS_IN = brt_s;
        push_model();
        @(negedge CLK_IN);
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cycle('0, '0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led"}, 32'(LED_OUT), 0);
        chk({tag, "_err"}, 32'(ERROR_LATCHED_OUT), 0);
        chk({tag, "_rep"}, 32'(ANIMATION_REPEAT_OUT), 0);
    endtask

    task automatic release_reset();
        RESET_IN = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge CLK_IN);
            #1;
            if (mon_en && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk($sformatf("led@%0d", mon_e.edge_no), 32'(LED_OUT), 32'(mon_e.led));
                chk($sformatf("err_latched@%0d", mon_e.edge_no), 32'(ERROR_LATCHED_OUT), 32'(mon_e.err));
                chk($sformatf("anim_repeat@%0d", mon_e.edge_no), 32'(ANIMATION_REPEAT_OUT), 32'(mon_e.rep));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge CLK_IN);
        chk_zero("in_reset");
        release_reset();

        idle(300);                                  // disconnected: pulse only
        cycle(2'b01, 2'b00, 2'b00);                 // one-cycle error on device 0
        idle(300);
        cycle(2'b01, 2'b01, 2'b00);                 // error and clear together
        idle(5);
        cycle(2'b00, 2'b01, 2'b00);                 // lone clear
        idle(20);

        conn_s = 2'b11;
        cycle(2'b00, 2'b00, 2'b01);
        idle(14);
        cycle(2'b00, 2'b00, 2'b01);                 // re-strobe with 5 cycles left
        idle(300);

        oen_s = 2'b10;
        mode_s = {3'd1, 3'd0};
        idle(40);
        brt_s = 3'd3;
        idle(40);
        brt_s = 3'd0;
        idle(40);
        mode_s = {3'd6, 3'd0};
        brt_s = 3'd7;
        idle(40);
        for (int m = 0; m < 8; m++) begin
            mode_s = {3'(m), 3'(7 - m)};
            oen_s = 2'b11;
            idle(35);
        end
        oen_s = 2'b00;

        cycle(2'b11, 2'b00, 2'b00);
        idle(10);
        @(posedge CLK_IN);
        #2;
        RESET_IN = 1'b0;
        #1;
        mon_en = 1'b0;
        chk_zero("async_reset");
        exp_q.delete();
        @(negedge CLK_IN);
        @(negedge CLK_IN);
        chk_zero("held_reset");
        conn_s = 2'b00;
        release_reset();
        idle(300);

        for (int r = 0; r < 3000; r++) begin
            if ($urandom % 97 == 0) conn_s = 2'($urandom);
            if ($urandom % 80 == 0) oen_s = 2'($urandom);
            if ($urandom % 40 == 0) mode_s = 6'($urandom);
            if ($urandom % 30 == 0) brt_s = 3'($urandom);
            cycle({($urandom % 60 == 0), ($urandom % 60 == 0)},
                  {($urandom % 15 == 0), ($urandom % 15 == 0)},
                  {($urandom % 25 == 0), ($urandom % 25 == 0)});
        end
        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spio_status_led_generator_multi.md
Name: spio_status_led_generator_multi

Overview:
Next-generation PWM status LED driver for NUM_DEVICES links/devices. It adds sticky per-device error latching with explicit clear, global brightness scaling, and per-device host override of the displayed animation. It also provides a true full-on duty level. It sits beside the link/device status logic and drives board LEDs directly.

Parameters:
NUM_DEVICES, 1, number of devices/LEDs
PWM_BITS, 7, PWM counter width; duty range 0..2^PWM_BITS
ANIMATION_PERIOD_BITS, 27, animation period = 2^ANIMATION_PERIOD_BITS cycles
PULSE_CYCLES, 7500000, pulse length in cycles; must be < 2^(ANIMATION_PERIOD_BITS-1)
BLINK_BIT, 22, period-counter bit driving activity blink; < ANIMATION_PERIOD_BITS
ACTIVITY_TIMEOUT, 18750000, cycles activity stays asserted after last ACTIVITY_IN pulse
ACTIVITY_TIMEOUT_BITS, 25, timeout counter width; must hold ACTIVITY_TIMEOUT

Ports:
CLK_IN  in  1  sole clock
RESET_IN  in  1  asynchronous, active-low reset
ERROR_IN  in  NUM_DEVICES  active-high error events, level or pulse
ERROR_CLEAR_IN  in  NUM_DEVICES  one-cycle pulse clears the latched error
CONNECTED_IN  in  NUM_DEVICES  active-high link connected
ACTIVITY_IN  in  NUM_DEVICES  active-high activity strobe
BRIGHTNESS_IN  in  PWM_BITS  global brightness; all-ones = unscaled
OVERRIDE_EN_IN  in  NUM_DEVICES  forces the override mode for that device
OVERRIDE_MODE_IN  in  3*NUM_DEVICES  per-device mode, bits [3i+2:3i]
ERROR_LATCHED_OUT  out  NUM_DEVICES  sticky error flag per device
LED_OUT  out  NUM_DEVICES  PWM LED drive
ANIMATION_REPEAT_OUT  out  1  one-cycle pulse per animation loop

Behaviour:
- Reset (RESET_IN low, asynchronous): all counters, timeouts, error latches, duty registers, LED_OUT, ANIMATION_REPEAT_OUT and ERROR_LATCHED_OUT go to 0. Release is synchronous to CLK_IN.
- pwm_cnt (PWM_BITS wide) and period (ANIMATION_PERIOD_BITS wide) are free-running +1 counters that wrap modulo 2^width.
- ANIMATION_REPEAT_OUT is registered: high for one cycle, on the cycle after period == 0.
- Define FULL = 2^PWM_BITS. Animation values are PWM_BITS+1 wide and registered one cycle behind period:
  - pulse = FULL if ((period - 2^(ANIMATION_PERIOD_BITS-1)) mod 2^ANIMATION_PERIOD_BITS) < PULSE_CYCLES, else 0.
  - inv_pulse = FULL - pulse.
  - blink = FULL if period[BLINK_BIT], else 0.
  - throb: let t = period[A-2:A-1-PWM_BITS], where A = ANIMATION_PERIOD_BITS. throb = t if period[A-1] == 0, else (2^PWM_BITS-1) - t. Zero-extended.
- Error latch, per device, per cycle:
  - ERROR_IN[i] set → latch 1. Error wins over a simultaneous clear.
  - Else ERROR_CLEAR_IN[i] → latch 0.
  - ERROR_LATCHED_OUT[i] = latch register, so it rises 1 cycle after ERROR_IN.
- Activity timeout, per device:
  - ACTIVITY_IN → counter loaded with ACTIVITY_TIMEOUT (retriggerable).
  - Else, if counter != 0, decrement.
  - active = (counter != 0).
- Per-device state, combinational from registered inputs, priority order:
  - ERROR (latch) → inv_pulse
  - ACTIVE (connected & active) → blink
  - IDLE (connected) → throb
  - DISCONNECTED → pulse
- Override: when OVERRIDE_EN_IN[i] is set, the mode replaces the state selection:
  - 0 = 0 (off), 1 = FULL, 2 = pulse, 3 = inv_pulse, 4 = blink, 5 = throb, 6/7 = 0.
  - Override never alters the error latch or the timeout.
- Pipeline, with input change at edge k:
  - selected duty registered at k+1
  - scaled duty = (duty * (BRIGHTNESS_IN + 1)) >> PWM_BITS, registered at k+2; product width 2*PWM_BITS+1, truncation toward zero
  - LED_OUT[i] = (pwm_cnt < scaled) registered at k+3
- Duty boundaries: duty FULL with BRIGHTNESS all-ones gives LED_OUT constantly 1; duty 0 gives constantly 0. BRIGHTNESS 0 gives scaled = duty >> PWM_BITS, so only FULL yields 1/FULL.
- Reset mid-operation clears the latches. Devices show pulse again after release, even if an error was latched before reset.

Test Plan:
Use PWM_BITS=3, ANIMATION_PERIOD_BITS=8, PULSE_CYCLES=16, BLINK_BIT=4, ACTIVITY_TIMEOUT=20, ACTIVITY_TIMEOUT_BITS=5, NUM_DEVICES=2, BRIGHTNESS=7.
1. Reset, then all inputs 0 → LED_OUT high only for period 128..143 (pulse). ANIMATION_REPEAT_OUT pulses every 256 cycles. All outputs 0 during reset.
2. ERROR_IN[0] pulse for 1 cycle → ERROR_LATCHED_OUT[0]=1 next cycle and holds. LED0 is on except during period 128..143. ERROR_IN and ERROR_CLEAR_IN asserted on the same cycle → latch stays 1. A lone clear pulse → latch 0.
3. CONNECTED=1, one ACTIVITY pulse → LED blinks (period[4]) for 20 cycles after the strobe, then throbs. A re-strobe at count 5 reloads to 20.
4. CONNECTED=1, idle, period=64 → t=4, duty 4, LED on 4 of 8 PWM slots. At period=192 → duty 3.
5. OVERRIDE_EN[1]=1, mode 1, BRIGHTNESS=7 → LED1 constant 1. BRIGHTNESS=3 → duty 4, 50% on. Mode 6 → LED1 off. Mode change is visible on LED_OUT 3 cycles later.
6. Assert RESET_IN low asynchronously mid-cycle while the error is latched → outputs 0 immediately. After release, the latch is 0 and the pulse animation resumes.
